// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Arbitrates the PTW (0), LOAD (1) and STORE (2) request ports onto the single
//   blocking request/response interface of the dcache controller. One
//   transaction is in flight at a time. The winner is latched into a holding
//   register, presented to the controller until granted, and the completion is
//   routed back to the owning port. Fixed priority PTW > LOAD > STORE, with an
//   age counter that lets a starved STORE request win.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   port_req_i[3]           per-port request valid
//   port_addr_i/we/be/wdata/size   per-port request fields, slice [i*W +: W]
//   port_gnt_o[3]           one-hot accept pulse (IDLE only, combinational)
//   port_rvalid_o[3]        one-hot completion pulse to the owning port
//   port_rdata_o            read data, pass-through of mem_rdata_i
//   mem_req_o, mem_gnt_i    request handshake to the controller
//   mem_addr/we/be/wdata/size_o    holding-register copy of the owning request
//   mem_rvalid_i, mem_rdata_i      controller completion
//   busy_o                  transaction in flight
//   owner_o                 owning port, 0 when idle
//   err_o                   sticky: completion seen outside WAIT_RSP

module dcache_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 34,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2:0]                    port_req_i,
  input  logic [3*ADDR_WIDTH-1:0]       port_addr_i,
  input  logic [2:0]                    port_we_i,
  input  logic [3*(DATA_WIDTH/8)-1:0]   port_be_i,
  input  logic [3*DATA_WIDTH-1:0]       port_wdata_i,
  input  logic [3*2-1:0]                port_size_i,
  output logic [2:0]                    port_gnt_o,
  output logic [2:0]                    port_rvalid_o,
  output logic [DATA_WIDTH-1:0]         port_rdata_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_WIDTH/8-1:0]       mem_be_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  output logic [1:0]                    mem_size_o,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  output logic                          busy_o,
  output logic [1:0]                    owner_o,
  output logic                          err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0]  AGE_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    PORT_PTW   = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_STORE = 2'd2
  } port_sel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [3:0]              store_age, store_age_next;
  port_sel_t               winner;
  logic                    capture;

  logic [ADDR_WIDTH-1:0]   hold_addr;
  logic                    hold_we;
  logic [BE_WIDTH-1:0]     hold_be;
  logic [DATA_WIDTH-1:0]   hold_wdata;
  logic [1:0]              hold_size;
  port_sel_t               hold_owner;
  logic                    err;

  // Starvation override first, otherwise lowest set index wins.
  always_comb begin
    winner = PORT_STORE;
    if (port_req_i[2] && (store_age == AGE_LIMIT)) begin
      winner = PORT_STORE;
    end else if (port_req_i[0]) begin
      winner = PORT_PTW;
    end else if (port_req_i[1]) begin
      winner = PORT_LOAD;
    end
  end

  always_comb begin
    state_next     = state;
    store_age_next = store_age;
    capture        = 1'b0;
    port_gnt_o     = 3'b000;
    port_rvalid_o  = 3'b000;
    mem_req_o      = 1'b0;
    case (state)
      IDLE: begin
        if (!port_req_i[2]) begin
          store_age_next = 4'd0;
        end
        if (|port_req_i) begin
          capture            = 1'b1;
          port_gnt_o[winner] = 1'b1;
          state_next         = REQ;
          if (winner == PORT_STORE) begin
            store_age_next = 4'd0;
          end else if (port_req_i[2] && (store_age < AGE_LIMIT)) begin
            store_age_next = store_age + 4'd1;
          end
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) begin
          port_rvalid_o[hold_owner] = 1'b1;
          state_next                = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      store_age <= 4'd0;
    end else begin
      state     <= state_next;
      store_age <= store_age_next;
    end
  end

  // Holding register only loads on an IDLE arbitration, so the controller sees
  // a stable request no matter what the ports do while it is busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_addr  <= '0;
      hold_we    <= 1'b0;
      hold_be    <= '0;
      hold_wdata <= '0;
      hold_size  <= 2'd0;
      hold_owner <= PORT_PTW;
    end else if (capture) begin
      hold_addr  <= port_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      hold_we    <= port_we_i[winner];
      hold_be    <= port_be_i[winner*BE_WIDTH +: BE_WIDTH];
      hold_wdata <= port_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
      hold_size  <= port_size_i[winner*2 +: 2];
      hold_owner <= winner;
    end
  end

  // A completion is only legal in WAIT_RSP; anything else is dropped and flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (mem_rvalid_i && (state != WAIT_RSP)) begin
      err <= 1'b1;
    end
  end

  assign port_rdata_o = mem_rdata_i;
  assign mem_addr_o   = hold_addr;
  assign mem_we_o     = hold_we;
  assign mem_be_o     = hold_be;
  assign mem_wdata_o  = hold_wdata;
  assign mem_size_o   = hold_size;
  assign busy_o       = (state != IDLE);
  assign owner_o      = busy_o ? hold_owner : 2'd0;
  assign err_o        = err;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;

  localparam int AW = 34;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rsp_t;

  logic            clk;
  logic            rst;
  logic [2:0]      port_req;
  logic [3*AW-1:0] port_addr;
  logic [2:0]      port_we;
  logic [3*BW-1:0] port_be;
  logic [3*DW-1:0] port_wdata;
  logic [5:0]      port_size;
  logic [2:0]      port_gnt;
  logic [2:0]      port_rvalid;
  logic [DW-1:0]   port_rdata;
  logic            mem_req;
  logic            mem_gnt;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [BW-1:0]   mem_be;
  logic [DW-1:0]   mem_wdata;
  logic [1:0]      mem_size;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic [1:0]      owner;
  logic            err;

  int checks   = 0;
  int failures = 0;

  int   gnt_q[$];
  rsp_t rsp_q[$];

  localparam logic [AW-1:0] A0 = 34'h1_0000_0000;
  localparam logic [AW-1:0] A1 = 34'h0_0000_2000;
  localparam logic [AW-1:0] A2 = 34'h2_AAAA_5554;
  localparam logic [31:0]   WD2 = 32'h1234_5678;

  dcache_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .port_req_i   (port_req),
    .port_addr_i  (port_addr),
    .port_we_i    (port_we),
    .port_be_i    (port_be),
    .port_wdata_i (port_wdata),
    .port_size_i  (port_size),
    .port_gnt_o   (port_gnt),
    .port_rvalid_o(port_rvalid),
    .port_rdata_o (port_rdata),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_size_o   (mem_size),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy),
    .owner_o      (owner),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every grant / completion pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (port_gnt != 3'b000) begin
        if (gnt_q.size() == 0) begin
          check("unexpected_gnt", 64'(port_gnt), 64'(0));
        end else begin
          int e;
          logic [2:0] oh;
          e  = gnt_q.pop_front();
          oh = 3'b001 << e;
          check("gnt", 64'(port_gnt), 64'(oh));
        end
      end
      if (port_rvalid != 3'b000) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rvalid", 64'(port_rvalid), 64'(0));
        end else begin
          rsp_t r;
          logic [2:0] oh;
          r  = rsp_q.pop_front();
          oh = 3'b001 << r.port;
          check("rvalid", 64'(port_rvalid), 64'(oh));
          check("rdata", 64'(port_rdata), 64'(r.data));
        end
      end
    end
  end

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic we,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic [1:0] sz);
    port_addr[p*AW +: AW]  = a;
    port_we[p]             = we;
    port_be[p*BW +: BW]    = be;
    port_wdata[p*DW +: DW] = wd;
    port_size[p*2 +: 2]    = sz;
  endtask

  // Called just after a rising edge with the DUT in IDLE and port_req already set.
  task automatic run_txn(input int p, input logic [AW-1:0] exp_addr, input logic exp_we,
                         input logic [DW-1:0] exp_wdata, input logic [DW-1:0] rdata,
                         input int gnt_wait, input logic [2:0] req_after, input bit scramble);
    gnt_q.push_back(p);
    @(posedge clk); #1;
    port_req = req_after;
    check("c1_mem_req", 64'(mem_req), 64'(1));
    check("c1_mem_addr", 64'(mem_addr), 64'(exp_addr));
    check("c1_mem_we", 64'(mem_we), 64'(exp_we));
    check("c1_mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    check("c1_owner", 64'(owner), 64'(p));
    for (int i = 0; i < gnt_wait; i++) begin
      if (scramble) begin
        port_addr  = {6'($urandom), $urandom, $urandom, $urandom};
        port_wdata = {$urandom, $urandom, $urandom};
        port_we    = 3'($urandom);
        port_req   = 3'($urandom);
      end
      @(posedge clk); #1;
      check("wait_mem_req", 64'(mem_req), 64'(1));
      check("wait_mem_addr", 64'(mem_addr), 64'(exp_addr));
      check("wait_mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      check("wait_mem_we", 64'(mem_we), 64'(exp_we));
    end
    port_req = req_after;
    mem_gnt  = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("rsp_busy", 64'(busy), 64'(1));
    check("rsp_mem_req", 64'(mem_req), 64'(0));
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    rsp_q.push_back('{port: p, data: rdata});
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("done_busy", 64'(busy), 64'(0));
    check("done_owner", 64'(owner), 64'(0));
  endtask

  initial begin
    rst        = 1'b1;
    port_req   = '0;
    port_addr  = '0;
    port_we    = '0;
    port_be    = '0;
    port_wdata = '0;
    port_size  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 64'(port_gnt), 64'(0));
    check("rst_rvalid", 64'(port_rvalid), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_fields", 64'({mem_we, mem_be, mem_wdata, mem_size}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single load on LOAD port.
    set_port(1, 34'h0_8000_1004, 1'b0, 4'hF, 32'h0, 2'd2);
    port_req = 3'b010;
    run_txn(1, 34'h0_8000_1004, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 3'b000, 1'b0);
    check("load_be", 64'(mem_be), 64'(4'hF));
    check("load_size", 64'(mem_size), 64'(2));

    // All three ports at once, each drops its request once granted.
    set_port(0, A0, 1'b0, 4'hF, 32'h0, 2'd2);
    set_port(1, A1, 1'b0, 4'h3, 32'h0, 2'd1);
    set_port(2, A2, 1'b1, 4'hF, WD2, 2'd2);
    port_req = 3'b111;
    run_txn(0, A0, 1'b0, 32'h0, 32'h1111_0000, 0, 3'b110, 1'b0);
    run_txn(1, A1, 1'b0, 32'h0, 32'h2222_0001, 0, 3'b100, 1'b0);
    run_txn(2, A2, 1'b1, WD2, 32'h3333_0002, 0, 3'b000, 1'b0);

    // Starvation: STORE loses four times to PTW, then wins with PTW valid.
    for (int k = 0; k < 4; k++) begin
      port_req = 3'b111;
      run_txn(0, A0, 1'b0, 32'h0, 32'hA000_0000 + 32'(k), 0, 3'b110, 1'b0);
    end
    port_req = 3'b111;
    run_txn(2, A2, 1'b1, WD2, 32'hB000_0000, 0, 3'b011, 1'b0);
    // Age cleared: PTW wins again over a still-pending STORE.
    port_req = 3'b111;
    run_txn(0, A0, 1'b0, 32'h0, 32'hC000_0000, 0, 3'b000, 1'b0);

    // Controller withholds grant for 10 cycles while port inputs churn.
    set_port(2, A2, 1'b1, 4'hF, WD2, 2'd2);
    port_req = 3'b100;
    run_txn(2, A2, 1'b1, WD2, 32'h5555_AAAA, 10, 3'b000, 1'b1);

    // Spurious completion in IDLE.
    port_req   = 3'b000;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_0001;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("idle_spur_err", 64'(err), 64'(1));
    check("idle_spur_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check("idle_spur_err_sticky", 64'(err), 64'(1));
    rst = 1'b1;
    #1;
    check("err_cleared_by_rst", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Spurious completion in REQ, then again coinciding with the grant.
    set_port(1, A1, 1'b0, 4'h3, 32'h0, 2'd1);
    port_req = 3'b010;
    gnt_q.push_back(1);
    @(posedge clk); #1;
    port_req   = 3'b000;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_0002;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("req_spur_err", 64'(err), 64'(1));
    check("req_spur_still_req", 64'(mem_req), 64'(1));
    check("req_spur_owner", 64'(owner), 64'(1));
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("gnt_spur_busy", 64'(busy), 64'(1));
    check("gnt_spur_mem_req", 64'(mem_req), 64'(0));
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_0003;
    rsp_q.push_back('{port: 1, data: 32'h7777_0003});
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("spur_done_busy", 64'(busy), 64'(0));
    check("spur_err_sticky", 64'(err), 64'(1));

    // Reset asserted in WAIT_RSP takes effect without a clock edge.
    set_port(1, A1, 1'b0, 4'h3, 32'h0, 2'd1);
    port_req = 3'b010;
    gnt_q.push_back(1);
    @(posedge clk); #1;
    port_req = 3'b000;
    mem_gnt  = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'(1));
    check("pre_rst_owner", 64'(owner), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_mem_req", 64'(mem_req), 64'(0));
    check("async_rst_owner", 64'(owner), 64'(0));
    check("async_rst_mem_addr", 64'(mem_addr), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_port(2, 34'h0_0000_0040, 1'b1, 4'hC, 32'hCAFE_F00D, 2'd2);
    port_req = 3'b100;
    run_txn(2, 34'h0_0000_0040, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 3'b000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("gnt_queue_drained", 64'(gnt_q.size()), 64'(0));
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
